// File: rtl/mux16_rr_sched_if.sv
// ============================================================================
// Module   : mux16_rr_sched_if
// Brief    : Requester / shared-mux / downstream bundle for mux16_rr_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux16_rr_sched_if #(
  parameter int WIDTH = 8
);
  logic [15:0]      req;
  logic [15:0]      gnt;
  logic [3:0]       sel;
  logic [WIDTH-1:0] mux_in;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  // master = the scheduler, slave = requesters, mux and downstream sink
  modport master (
    input  req, mux_in, out_ready,
    output gnt, sel, out_data, out_valid, busy
  );

  modport slave (
    output req, mux_in, out_ready,
    input  gnt, sel, out_data, out_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/mux16_rr_sched.sv
// ============================================================================
// Module   : mux16_rr_sched
// Brief    : Round-robin owner of the shared 16:1 result mux, with a
//            valid/ready output slice. Optional burst mode: MUX_SCHED_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux16_rr_sched #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mux16_rr_sched_if.master  bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_xfer = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [3:0]       r_ptr;
  logic [3:0]       r_sel;
  logic [15:0]      r_gnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  logic [3:0]       w_winner;
  logic [3:0]       w_idx;
  logic             w_found;
  logic             w_load_sel;
  logic             w_capture;
  logic             w_accept;
  logic             w_burst_go;

  // The burst counter is 3 bits wide, so a larger limit cannot be honoured.
  generate
    if (MAX_BURST < 1 || MAX_BURST > 8) begin : g_bad_max_burst
      $error("mux16_rr_sched: MAX_BURST must be in 1..8");
    end
  endgenerate

  // First set request at or after r_ptr, wrapping modulo 16.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int i = 0; i < 16; i++) begin
      w_idx = r_ptr + 4'(i);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_found) w_state_nxt = c_st_xfer;
      c_st_xfer: w_state_nxt = c_st_hold;
      c_st_hold: if (w_accept) w_state_nxt = w_burst_go ? c_st_xfer : c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_load_sel = 1'b0;
    w_capture  = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      c_st_idle: w_load_sel = w_found;
      c_st_xfer: w_capture  = 1'b1;
      c_st_hold: w_accept   = r_out_valid && bus.out_ready;
      default: ;
    endcase
  end

`ifdef MUX_SCHED_BURST_EN
  localparam logic [2:0] c_cnt_last = 3'(MAX_BURST - 1);

  logic [2:0] r_cnt;

  // Stay on the current owner while it still requests and has burst budget.
  assign w_burst_go = bus.req[r_sel] && (r_cnt < c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
    end else if (w_load_sel) begin
      r_cnt <= 3'd0;
    end else if (w_accept) begin
      r_cnt <= w_burst_go ? r_cnt + 3'd1 : 3'd0;
    end
  end
`else
  assign w_burst_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 4'd0;
      r_sel       <= 4'd0;
      r_gnt       <= 16'd0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_gnt <= 16'd0;
      if (w_load_sel) begin
        r_sel <= w_winner;
      end
      if (w_capture) begin
        r_out_data  <= bus.mux_in;
        r_out_valid <= 1'b1;
        r_gnt       <= 16'd1 << r_sel;
      end
      if (w_accept) begin
        r_out_valid <= 1'b0;
        if (!w_burst_go) begin
          r_ptr <= r_sel + 4'd1;
        end
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_mux16_rr_sched.sv
// ============================================================================
// Module   : tb_mux16_rr_sched
// Brief    : Directed vector table plus hand sequences for mux16_rr_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux16_rr_sched;

  localparam int c_max_burst = 4;
`ifdef MUX_SCHED_BURST_EN
  localparam int c_burst = 1;
`else
  localparam int c_burst = 0;
`endif

  typedef struct {
    logic [15:0] req;
    logic [3:0]  idx;
    logic [7:0]  base;
    logic [7:0]  data;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] mux_base;
  int         n_checks;
  int         n_err;
  vec_t       vecs[10];

  mux16_rr_sched_if #(.WIDTH(8)) bus ();

  mux16_rr_sched #(.WIDTH(8), .MAX_BURST(c_max_burst)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared result mux model: input i carries mux_base + i.
  assign bus.mux_in = mux_base + {4'd0, bus.sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req = 16'd0;
    rst_n   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transfer from a requester that drops req as soon as it is granted.
  task automatic run_xfer(input vec_t v);
    @(negedge clk);
    mux_base      = v.base;
    bus.req       = v.req;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("sel", 32'(bus.sel), 32'(v.idx));
    check("gnt_early", 32'(bus.gnt), 32'd0);
    check("busy_sel", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("gnt", 32'(bus.gnt), 32'(16'd1 << v.idx));
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("out_data", 32'(bus.out_data), 32'(v.data));
    bus.req = 16'd0;
    @(negedge clk);
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    check("gnt_pulse", 32'(bus.gnt), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  // Held requests, always ready: record n grants and compare to rotation.
  task automatic collect(input logic [15:0] r, input int n, input int modulus);
    int t;
    int e_idx;
    @(negedge clk);
    mux_base      = 8'd1;
    bus.req       = r;
    bus.out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (bus.gnt == 16'd0 && t < 10) begin
        @(negedge clk);
        t++;
      end
      e_idx = ((c_burst != 0) ? (k / c_max_burst) : k) % modulus;
      if (t >= 10) begin
        n_checks++;
        n_err++;
        $display("FAIL gnt_timeout: grant %0d never seen, expected index %0d", k, e_idx);
      end else begin
        check("rot_gnt", 32'(bus.gnt), 32'(16'd1 << e_idx));
        check("rot_data", 32'(bus.out_data), 32'(e_idx + 1));
        @(negedge clk);
      end
    end
    bus.req = 16'd0;
    t = 0;
    while (bus.busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rot_end_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    mux_base      = 8'd0;
    bus.req       = 16'd0;
    bus.out_ready = 1'b0;

    // ptr starts at 0 and advances to winner+1 after each transfer.
    vecs[0] = '{req: 16'h0001, idx: 4'd0,  base: 8'd23,  data: 8'd23};
    vecs[1] = '{req: 16'h0001, idx: 4'd0,  base: 8'd10,  data: 8'd10};
    vecs[2] = '{req: 16'h8001, idx: 4'd15, base: 8'd0,   data: 8'd15};
    vecs[3] = '{req: 16'h8001, idx: 4'd0,  base: 8'd5,   data: 8'd5};
    vecs[4] = '{req: 16'h8001, idx: 4'd15, base: 8'd5,   data: 8'd20};
    vecs[5] = '{req: 16'h0010, idx: 4'd4,  base: 8'd100, data: 8'd104};
    vecs[6] = '{req: 16'h0030, idx: 4'd5,  base: 8'd100, data: 8'd105};
    vecs[7] = '{req: 16'h0030, idx: 4'd4,  base: 8'd1,   data: 8'd5};
    vecs[8] = '{req: 16'h8000, idx: 4'd15, base: 8'd240, data: 8'd255};
    vecs[9] = '{req: 16'hFFFE, idx: 4'd1,  base: 8'd2,   data: 8'd3};

    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_xfer(vecs[i]);
    end

    // Backpressure: ptr=2, requester 6 granted, sink stalls for 10 cycles.
    @(negedge clk);
    mux_base      = 8'd50;
    bus.req       = 16'h0040;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_gnt", 32'(bus.gnt), 32'h0040);
    check("bp_data", 32'(bus.out_data), 32'd56);
    bus.req = 16'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      check("bp_data_hold", 32'(bus.out_data), 32'd56);
      check("bp_no_gnt", 32'(bus.gnt), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("noreq_gnt", 32'(bus.gnt), 32'd0);
      check("noreq_busy", 32'(bus.busy), 32'd0);
    end

    // Reset while holding a byte: ptr=7, requester 8 wins, then rst_n drops.
    @(negedge clk);
    bus.req       = 16'h0100;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("hr_gnt", 32'(bus.gnt), 32'h0100);
    bus.req = 16'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("hr_valid", 32'(bus.out_valid), 32'd0);
    check("hr_gnt0", 32'(bus.gnt), 32'd0);
    check("hr_sel", 32'(bus.sel), 32'd0);
    check("hr_busy", 32'(bus.busy), 32'd0);
    check("hr_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // With ptr back at 0, bit 2 must beat bit 8.
    run_xfer('{req: 16'h0104, idx: 4'd2, base: 8'd7, data: 8'd9});

    do_reset();
    collect(16'hFFFF, 17, 16);

    do_reset();
    collect(16'h0003, 9, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
